// File: rtl/idct4_stream.sv
`timescale 1ns/1ps
// idct4_stream: streaming 4-point integer butterfly transform.
// Collects A0..A3 serially, transforms them (inverse or forward, chosen on beat 0),
// and replays the four results serially with valid/ready on both sides.
// Optional build macro: IDCT4_ROUND_EN (round-half-up on inverse results).
module idct4_stream #(
    parameter int WIDTH = 8
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    cfg_inverse,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_last
);

    // Three extra bits keep the rounding offset from wrapping at the extremes.
    localparam int IW = WIDTH + 3;
    typedef logic signed [IW-1:0] ext_t;

    logic signed [WIDTH-1:0] r_a0, r_a1, r_a2;
    logic signed [WIDTH-1:0] r_buf [4];
    logic [1:0]              r_in_cnt;
    logic [1:0]              r_out_cnt;
    logic                    r_out_full;
    logic                    r_inv;
    logic                    r_rdy;

    ext_t                    w_e   [4];
    ext_t                    w_pre [4];
    ext_t                    w_sum [4];
    logic signed [WIDTH-1:0] w_res [4];
    logic                    w_in_acc;
    logic                    w_out_acc;
    logic                    w_last_acc;

    function automatic logic signed [WIDTH-1:0] sat(input ext_t v);
        ext_t hi;
        ext_t lo;
        hi = (ext_t'(1) <<< (WIDTH - 1)) - ext_t'(1);
        lo = -(ext_t'(1) <<< (WIDTH - 1));
        if (v > hi)      sat = hi[WIDTH-1:0];
        else if (v < lo) sat = lo[WIDTH-1:0];
        else             sat = v[WIDTH-1:0];
    endfunction

    assign m_valid    = r_out_full;
    assign m_data     = r_buf[r_out_cnt];
    assign m_last     = (r_out_cnt == 2'd3);
    assign w_out_acc  = m_valid && m_ready;
    assign w_last_acc = w_out_acc && m_last;
    // The last beat may enter on the same edge the buffer's final sample leaves.
    assign s_ready    = r_rdy && !((r_in_cnt == 2'd3) && r_out_full && !w_last_acc);
    assign w_in_acc   = s_valid && s_ready;

    // Butterfly on the three held samples plus the live fourth beat, then saturate.
    always_comb begin
        w_e[0] = ext_t'(r_a0);
        w_e[1] = ext_t'(r_a1);
        w_e[2] = ext_t'(r_a2);
        w_e[3] = ext_t'(s_data);
        if (r_inv) begin
            w_pre[0] = w_e[0] + w_e[2] + (w_e[1] <<< 1);
            w_pre[1] = w_e[0] - w_e[2] - (w_e[3] <<< 1);
            w_pre[2] = w_e[0] - w_e[2] + (w_e[3] <<< 1);
            w_pre[3] = w_e[0] + w_e[2] - (w_e[1] <<< 1);
            for (int unsigned i = 0; i < 4; i++) begin
`ifdef IDCT4_ROUND_EN
                w_sum[i] = (w_pre[i] + ext_t'(2)) >>> 2;
`else
                w_sum[i] = w_pre[i] >>> 2;
`endif
            end
        end else begin
            w_pre[0] = '0;
            w_pre[1] = '0;
            w_pre[2] = '0;
            w_pre[3] = '0;
            w_sum[0] = w_e[0] + w_e[1] + w_e[2] + w_e[3];
            w_sum[1] = w_e[0] - w_e[3];
            w_sum[2] = w_e[0] + w_e[3] - w_e[1] - w_e[2];
            w_sum[3] = w_e[2] - w_e[1];
        end
        for (int unsigned i = 0; i < 4; i++) begin
            w_res[i] = sat(w_sum[i]);
        end
    end

    // Input collector, mode latch, output buffer and replay counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_a0       <= '0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_out_full <= 1'b0;
            r_inv      <= 1'b0;
            r_rdy      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_rdy <= 1'b1;
            if (w_in_acc) begin
                r_in_cnt <= r_in_cnt + 2'd1;
                case (r_in_cnt)
                    2'd0: begin
                        r_a0  <= s_data;
                        r_inv <= cfg_inverse;
                    end
                    2'd1:    r_a1 <= s_data;
                    2'd2:    r_a2 <= s_data;
                    default: ;
                endcase
            end
            if (w_out_acc) begin
                r_out_cnt <= r_out_cnt + 2'd1;
                if (m_last) r_out_full <= 1'b0;
            end
            // A load overrides the clear from a simultaneous final-output accept.
            if (w_in_acc && (r_in_cnt == 2'd3)) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    r_buf[i] <= w_res[i];
                end
                r_out_full <= 1'b1;
                r_out_cnt  <= '0;
            end
        end
    end

endmodule
